// File: rtl/tm_pkg.sv
// Shared widths, FSM encoding and vote codes for the TM clause-vote path.
// Imported by clause_vote_accumulator and sat_add_signed.
package tm_pkg;

    localparam int DEF_CLASS_W     = 4;
    localparam int DEF_CLAUSE_W    = 9;
    localparam int DEF_SUM_W       = 10;
    localparam int DEF_NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        EMIT  = 2'd1,
        PRED  = 2'd2
    } state_t;

    // Two-bit signed vote: +1, 0, -1
    localparam logic [1:0] VOTE_ZERO = 2'b00;
    localparam logic [1:0] VOTE_POS  = 2'b01;
    localparam logic [1:0] VOTE_NEG  = 2'b11;

endpackage

// File: rtl/sat_add_signed.sv
// Saturating signed add of a +1/0/-1 step to a W-bit value.
// Ports: a (signed value), step (vote code), y (saturated result).
module sat_add_signed
    import tm_pkg::*;
#(
    parameter int W = DEF_SUM_W
) (
    input  logic [W-1:0] a,
    input  logic [1:0]   step,
    output logic [W-1:0] y
);

    localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    always_comb begin
        y = a;
        unique case (1'b1)
            (step == VOTE_POS): y = (a == MAX) ? a : a + 1'b1;
            (step == VOTE_NEG): y = (a == MIN) ? a : a - 1'b1;
            default:            y = a;
        endcase
    end

endmodule

// File: rtl/clause_vote_accumulator.sv
// Turns a clause-result stream into saturating per-class vote sums and
// an argmax prediction per sample.
// Ports: in_* beat stream (valid/ready), sum_* class sums (valid/ready),
// pred_* one-cycle prediction strobe, dup_drop/class_err drop pulses.
module clause_vote_accumulator
    import tm_pkg::*;
#(
    parameter int CLASS_W     = DEF_CLASS_W,
    parameter int CLAUSE_W    = DEF_CLAUSE_W,
    parameter int SUM_W       = DEF_SUM_W,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CLASS_W-1:0]  in_class,
    input  logic [CLAUSE_W-1:0] in_clause,
    input  logic                in_fire,
    input  logic                in_last,
    output logic                sum_valid,
    input  logic                sum_ready,
    output logic [CLASS_W-1:0]  sum_class,
    output logic [SUM_W-1:0]    sum_value,
    output logic                pred_valid,
    output logic [CLASS_W-1:0]  pred_class,
    output logic [SUM_W-1:0]    pred_sum,
    output logic                dup_drop,
    output logic                class_err
);

    state_t state, state_n;

    logic [SUM_W-1:0]    acc, acc_n;
    logic [CLASS_W-1:0]  cur_class, cur_class_n;
    logic                have_data, have_data_n;
    logic                prev_valid, prev_valid_n;
    logic [CLASS_W-1:0]  prev_class, prev_class_n;
    logic [CLAUSE_W-1:0] prev_clause, prev_clause_n;
    logic                last_pend, last_pend_n;
    logic                fin, fin_n;
    logic                best_valid, best_valid_n;
    logic [CLASS_W-1:0]  best_class, best_class_n;
    logic [SUM_W-1:0]    best_sum, best_sum_n;
    logic [CLASS_W-1:0]  sum_class_n, pred_class_n;
    logic [SUM_W-1:0]    sum_value_n, pred_sum_n;
    logic                dup_n, err_n;

    logic                accept, legal, dup, better;
    logic [1:0]          vote;
    logic [SUM_W-1:0]    acc_vote, vote_ext, best_inc;

    assign in_ready   = (state == ACCUM);
    assign sum_valid  = (state == EMIT);
    assign pred_valid = (state == PRED);

    assign accept = in_valid && in_ready;
    assign legal  = int'(in_class) < NUM_CLASSES;
    assign dup    = prev_valid && (in_class == prev_class)
                    && (in_clause == prev_clause);
    assign vote   = !in_fire     ? VOTE_ZERO :
                    in_clause[0] ? VOTE_NEG  : VOTE_POS;
    assign vote_ext = {{(SUM_W-2){vote[1]}}, vote};

    sat_add_signed #(.W(SUM_W)) u_acc_add (
        .a    (acc),
        .step (vote),
        .y    (acc_vote)
    );

    // sum > best  <=>  sum >= best+1, unless best+1 saturated
    sat_add_signed #(.W(SUM_W)) u_best_inc (
        .a    (best_sum),
        .step (VOTE_POS),
        .y    (best_inc)
    );

    assign better = !best_valid
                    || (($signed(sum_value) >= $signed(best_inc))
                        && (best_inc != best_sum));

    always_comb begin
        state_n       = state;
        acc_n         = acc;
        cur_class_n   = cur_class;
        have_data_n   = have_data;
        prev_valid_n  = prev_valid;
        prev_class_n  = prev_class;
        prev_clause_n = prev_clause;
        last_pend_n   = last_pend;
        fin_n         = fin;
        best_valid_n  = best_valid;
        best_class_n  = best_class;
        best_sum_n    = best_sum;
        sum_class_n   = sum_class;
        sum_value_n   = sum_value;
        pred_class_n  = pred_class;
        pred_sum_n    = pred_sum;
        dup_n         = 1'b0;
        err_n         = 1'b0;
        unique case (state)
            ACCUM: begin
                if (accept) begin
                    if (!legal || dup) begin
                        // dropped beat still closes the sample
                        err_n = !legal;
                        dup_n = legal;
                        if (in_last) begin
                            if (have_data) begin
                                sum_class_n = cur_class;
                                sum_value_n = acc;
                                fin_n       = 1'b1;
                                state_n     = EMIT;
                            end else begin
                                pred_class_n = best_class;
                                pred_sum_n   = best_sum;
                                state_n      = PRED;
                            end
                        end
                    end else begin
                        prev_valid_n  = 1'b1;
                        prev_class_n  = in_class;
                        prev_clause_n = in_clause;
                        cur_class_n   = in_class;
                        if (have_data && (in_class != cur_class)) begin
                            sum_class_n = cur_class;
                            sum_value_n = acc;
                            acc_n       = vote_ext;
                            last_pend_n = in_last;
                            state_n     = EMIT;
                        end else begin
                            acc_n       = acc_vote;
                            have_data_n = 1'b1;
                            if (in_last) begin
                                sum_class_n = in_class;
                                sum_value_n = acc_vote;
                                fin_n       = 1'b1;
                                state_n     = EMIT;
                            end
                        end
                    end
                end
            end
            EMIT: begin
                if (sum_ready) begin
                    if (better) begin
                        best_valid_n = 1'b1;
                        best_class_n = sum_class;
                        best_sum_n   = sum_value;
                    end
                    if (last_pend) begin
                        sum_class_n = cur_class;
                        sum_value_n = acc;
                        last_pend_n = 1'b0;
                        fin_n       = 1'b1;
                    end else if (fin) begin
                        pred_class_n = better ? sum_class : best_class;
                        pred_sum_n   = better ? sum_value : best_sum;
                        state_n      = PRED;
                    end else begin
                        state_n = ACCUM;
                    end
                end
            end
            PRED: begin
                best_valid_n = 1'b0;
                best_class_n = '0;
                best_sum_n   = '0;
                have_data_n  = 1'b0;
                prev_valid_n = 1'b0;
                fin_n        = 1'b0;
                acc_n        = '0;
                state_n      = ACCUM;
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ACCUM;
            acc         <= '0;
            cur_class   <= '0;
            have_data   <= 1'b0;
            prev_valid  <= 1'b0;
            prev_class  <= '0;
            prev_clause <= '0;
            last_pend   <= 1'b0;
            fin         <= 1'b0;
            best_valid  <= 1'b0;
            best_class  <= '0;
            best_sum    <= '0;
            sum_class   <= '0;
            sum_value   <= '0;
            pred_class  <= '0;
            pred_sum    <= '0;
            dup_drop    <= 1'b0;
            class_err   <= 1'b0;
        end else begin
            state       <= state_n;
            acc         <= acc_n;
            cur_class   <= cur_class_n;
            have_data   <= have_data_n;
            prev_valid  <= prev_valid_n;
            prev_class  <= prev_class_n;
            prev_clause <= prev_clause_n;
            last_pend   <= last_pend_n;
            fin         <= fin_n;
            best_valid  <= best_valid_n;
            best_class  <= best_class_n;
            best_sum    <= best_sum_n;
            sum_class   <= sum_class_n;
            sum_value   <= sum_value_n;
            pred_class  <= pred_class_n;
            pred_sum    <= pred_sum_n;
            dup_drop    <= dup_n;
            class_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_clause_vote_accumulator.sv
// Scoreboard bench for clause_vote_accumulator: directed samples push
// expected sums/predictions; a negedge monitor pops and compares.
module tb_clause_vote_accumulator;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_class = '0;
    logic [8:0] in_clause = '0;
    logic       in_fire = 1'b0;
    logic       in_last = 1'b0;
    logic       sum_valid;
    logic       sum_ready = 1'b1;
    logic [3:0] sum_class;
    logic [9:0] sum_value;
    logic       pred_valid;
    logic [3:0] pred_class;
    logic [9:0] pred_sum;
    logic       dup_drop;
    logic       class_err;

    int checks = 0;
    int errors = 0;
    int dup_cnt = 0;
    int err_cnt = 0;
    int exp_sc[$];
    int exp_sv[$];
    int exp_pc[$];
    int exp_ps[$];

    always #5 clock = ~clock;

    clause_vote_accumulator dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_class   (in_class),
        .in_clause  (in_clause),
        .in_fire    (in_fire),
        .in_last    (in_last),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum_class  (sum_class),
        .sum_value  (sum_value),
        .pred_valid (pred_valid),
        .pred_class (pred_class),
        .pred_sum   (pred_sum),
        .dup_drop   (dup_drop),
        .class_err  (class_err)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: compares every sum handshake and prediction strobe
    always @(negedge clock) begin
        if (dup_drop) dup_cnt++;
        if (class_err) err_cnt++;
        if (reset && sum_valid && sum_ready) begin
            if (exp_sc.size() == 0) begin
                check("unexpected_sum", 1, 0);
            end else begin
                check("sum_class", int'(sum_class), exp_sc.pop_front());
                check("sum_value", int'($signed(sum_value)),
                      exp_sv.pop_front());
            end
        end
        if (reset && pred_valid) begin
            if (exp_pc.size() == 0) begin
                check("unexpected_pred", 1, 0);
            end else begin
                check("pred_class", int'(pred_class), exp_pc.pop_front());
                check("pred_sum", int'($signed(pred_sum)),
                      exp_ps.pop_front());
            end
        end
    end

    task automatic exp_sum(input int c, input int v);
        exp_sc.push_back(c);
        exp_sv.push_back(v);
    endtask

    task automatic exp_pred(input int c, input int v);
        exp_pc.push_back(c);
        exp_ps.push_back(v);
    endtask

    task automatic send(input int c, input int cl, input bit f, input bit l);
        int n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid  = 1'b1;
        in_class  = 4'(c);
        in_clause = 9'(cl);
        in_fire   = f;
        in_last   = l;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_sc.size() != 0 || exp_pc.size() != 0) && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        if (exp_sc.size() != 0 || exp_pc.size() != 0) begin
            check("drain_timeout", 0, 1);
            exp_sc.delete(); exp_sv.delete();
            exp_pc.delete(); exp_ps.delete();
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        #12;
        check("rst_sum_valid", int'(sum_valid), 0);
        check("rst_pred_valid", int'(pred_valid), 0);
        check("rst_dup_drop", int'(dup_drop), 0);
        check("rst_class_err", int'(class_err), 0);
        check("rst_sum_value", int'(sum_value), 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_in_ready", int'(in_ready), 1);

        // +1 -1 +1 +1 within class 3
        exp_sum(3, 2); exp_pred(3, 2);
        send(3, 0, 1, 0); send(3, 1, 1, 0);
        send(3, 2, 1, 0); send(3, 4, 1, 1);
        wait_idle();

        // Two classes, sum_ready stalled on the first emit
        sum_ready = 1'b0;
        exp_sum(2, 2); exp_sum(5, 1); exp_pred(2, 2);
        send(2, 0, 1, 0); send(2, 2, 1, 0); send(5, 0, 1, 1);
        n = 0;
        while (!sum_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("stall_sum_valid", int'(sum_valid), 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_sum_class", int'(sum_class), 2);
            check("stall_sum_value", int'(sum_value), 2);
            check("stall_in_ready", int'(in_ready), 0);
            @(posedge clock); #1;
        end
        sum_ready = 1'b1;
        wait_idle();

        // Same beat three times: counted once
        dup_cnt = 0;
        exp_sum(1, 1); exp_pred(1, 1);
        send(1, 6, 1, 0); send(1, 6, 1, 0); send(1, 6, 1, 1);
        wait_idle();
        check("dup_pulses", dup_cnt, 2);

        // Positive saturation
        exp_sum(0, 511); exp_pred(0, 511);
        for (int i = 0; i < 600; i++)
            send(0, 2 * (i % 256), 1, i == 599);
        wait_idle();

        // Negative saturation
        exp_sum(0, -512); exp_pred(0, -512);
        for (int i = 0; i < 600; i++)
            send(0, 2 * (i % 256) + 1, 1, i == 599);
        wait_idle();

        // Tie keeps the earlier class
        exp_sum(4, 3); exp_sum(7, 3); exp_pred(4, 3);
        send(4, 0, 1, 0); send(4, 2, 1, 0); send(4, 4, 1, 0);
        send(7, 0, 1, 0); send(7, 2, 1, 0); send(7, 4, 1, 1);
        wait_idle();

        // Illegal class mid-sample is dropped
        err_cnt = 0;
        exp_sum(6, 2); exp_pred(6, 2);
        send(6, 0, 1, 0); send(12, 2, 1, 0); send(6, 4, 1, 1);
        wait_idle();
        check("class_err_pulses", err_cnt, 1);

        // Lone illegal beat with in_last: empty prediction
        err_cnt = 0;
        exp_pred(0, 0);
        send(12, 0, 1, 1);
        wait_idle();
        check("class_err_last", err_cnt, 1);

        // Reset while a sum is pending
        sum_ready = 1'b0;
        send(8, 0, 1, 0); send(8, 2, 1, 0); send(9, 0, 1, 0);
        @(posedge clock); #1;
        check("pre_rst_sum_valid", int'(sum_valid), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_sum_valid", int'(sum_valid), 0);
        sum_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        exp_sum(8, 1); exp_pred(8, 1);
        send(8, 0, 1, 1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=1 required=0");
        $fatal(1, "timeout");
    end

endmodule
